program_counter_stack: RTL and testbench

// - Program counter with an internal return-address stack.
// - Built from clocked storage and sits directly upstream of the memory array.
// - Drives the instruction fetch address each cycle.
// - Sequences increment, jump, call and return under a one-hot-free 3-bit opcode.
// - Flags stack full, empty and misuse.
//

---
 rtl/program_counter_stack.sv | 86 ++++++++
 tb/tb_program_counter_stack.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_counter_stack.sv
// program_counter_stack: fetch PC with an internal return-address stack.
// Define PC_STACK_TRAP_EN to make stack misuse a sticky trap that only rst_n clears.
module program_counter_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [2:0]               op,
  input  logic [WIDTH-1:0]         target,
  output logic [WIDTH-1:0]         pc,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     full,
  output logic                     empty,
  output logic                     err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_SP = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] stack [DEPTH];
  logic [WIDTH-1:0] pc_n, pc_inc;
  logic [AW:0]      sp_n;
  logic [AW-1:0]    rd_idx, wr_idx;
  logic             err_n, push, misuse;
`ifdef PC_STACK_TRAP_EN
  typedef enum logic {RUN, TRAP} state_t;
  state_t state, state_n;
`endif
  assign pc_inc = pc + WIDTH'(1);
  assign full   = sp == FULL_SP;
  assign empty  = sp == '0;
  assign rd_idx = AW'(sp - (AW+1)'(1));
  assign wr_idx = AW'(sp);
  always_comb begin
    pc_n   = pc;
    sp_n   = sp;
    err_n  = en ? 1'b0 : err;
    push   = 1'b0;
    misuse = 1'b0;
    if (en)
      case (op)
        3'b001: pc_n = pc_inc;
        3'b010: pc_n = target;
        3'b011: begin
          pc_n   = target;
          misuse = full;
          push   = !full;
          sp_n   = full ? sp : sp + (AW+1)'(1);
        end
        3'b100: begin
          misuse = empty;
          pc_n   = empty ? pc_inc : stack[rd_idx];
          sp_n   = empty ? sp : sp - (AW+1)'(1);
        end
        3'b101: sp_n = '0;
        default: ;
      endcase
    err_n = err_n | misuse;
`ifdef PC_STACK_TRAP_EN
    state_n = (state == TRAP || misuse) ? TRAP : RUN;
    if (state_n == TRAP) begin
      pc_n  = pc;
      sp_n  = sp;
      push  = 1'b0;
      err_n = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc  <= RESET_ADDR;
      sp  <= '0;
      err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else begin
      pc  <= pc_n;
      sp  <= sp_n;
      err <= err_n;
      if (push) stack[wr_idx] <= pc_inc;
    end
  end
`ifdef PC_STACK_TRAP_EN
  always_ff @(posedge clk) state <= !rst_n ? RUN : state_n;
`endif
endmodule

// File: tb/tb_program_counter_stack.sv
// tb_program_counter_stack: queue-model scoreboard plus directed checks for program_counter_stack.
module tb_program_counter_stack;
  localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, JMP = 3'd2, CALL = 3'd3, RET = 3'd4, CLR = 3'd5;
  typedef struct packed {
    logic [7:0] pc;
    logic [2:0] sp;
    logic       full, empty, err;
  } res_t;
  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] target = 8'd0;
  logic [7:0] pc;
  logic [2:0] sp;
  logic       full, empty, err;
  int nchk = 0, nerr = 0;
  res_t exp_q[$], obs_q[$];
  res_t e, o;
  logic [7:0] m_pc = 8'd0;
  logic [7:0] m_stk[$];
  logic       m_err = 1'b0, m_trap = 1'b0;

  program_counter_stack #(.WIDTH(8), .DEPTH(4), .RESET_ADDR(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .target(target),
    .pc(pc), .sp(sp), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, got %0d checks want completion", nchk);
    $fatal(1, "timeout");
  end

  // Applies one cycle of stimulus, advances the model, and records expected/observed results.
  task automatic drive(input logic r, input logic e_in, input logic [2:0] o_in, input logic [7:0] t);
    logic [7:0] ret_addr;
    rst_n = r; en = e_in; op = o_in; target = t;
    if (!r) begin
      m_pc = 8'h00; m_stk.delete(); m_err = 1'b0; m_trap = 1'b0;
    end else if (e_in && !m_trap) begin
      m_err = 1'b0;
      case (o_in)
        INC: m_pc = m_pc + 8'd1;
        JMP: m_pc = t;
        CALL:
          if (m_stk.size() < 4) begin
            ret_addr = m_pc + 8'd1;
            m_stk.push_back(ret_addr);
            m_pc = t;
          end else begin
            m_err = 1'b1;
`ifdef PC_STACK_TRAP_EN
            m_trap = 1'b1;
`else
            m_pc = t;
`endif
          end
        RET:
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin
            m_err = 1'b1;
`ifdef PC_STACK_TRAP_EN
            m_trap = 1'b1;
`else
            m_pc = m_pc + 8'd1;
`endif
          end
        CLR: m_stk.delete();
        default: ;
      endcase
    end
    exp_q.push_back('{m_pc, 3'(m_stk.size()), m_stk.size() == 4, m_stk.size() == 0, m_err});
    @(posedge clk);
    #1;
    obs_q.push_back('{pc, sp, full, empty, err});
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, CALL, 8'h55);
    nchk++; if (pc !== 8'h00) begin nerr++; $display("FAIL reset_pc: got %h want 00", pc); end
    nchk++; if (sp !== 3'd0) begin nerr++; $display("FAIL reset_sp: got %0d want 0", sp); end
    nchk++; if (empty !== 1'b1 || full !== 1'b0) begin nerr++; $display("FAIL reset_flags: got empty=%b full=%b want 1 0", empty, full); end
    nchk++; if (err !== 1'b0) begin nerr++; $display("FAIL reset_err: got %b want 0", err); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nchk++;
      if (o !== e) begin nerr++; $display("FAIL reset_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_inc_wrap();
    drive(1'b0, 1'b0, HOLD, 8'h00);
    for (int i = 0; i < 255; i++) drive(1'b1, 1'b1, INC, 8'h00);
    nchk++; if (pc !== 8'hff) begin nerr++; $display("FAIL inc_255: got %h want ff", pc); end
    drive(1'b1, 1'b1, INC, 8'h00);
    nchk++; if (pc !== 8'h00 || err !== 1'b0) begin nerr++; $display("FAIL inc_wrap: got pc=%h err=%b want 00 0", pc, err); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nchk++;
      if (o !== e) begin nerr++; $display("FAIL inc_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_nested();
    drive(1'b0, 1'b0, HOLD, 8'h00);
    drive(1'b1, 1'b1, JMP, 8'h10);
    drive(1'b1, 1'b1, CALL, 8'h40);
    nchk++; if (pc !== 8'h40 || sp !== 3'd1) begin nerr++; $display("FAIL call1: got pc=%h sp=%0d want 40 1", pc, sp); end
    drive(1'b1, 1'b1, CALL, 8'h80);
    nchk++; if (pc !== 8'h80 || sp !== 3'd2) begin nerr++; $display("FAIL call2: got pc=%h sp=%0d want 80 2", pc, sp); end
    drive(1'b1, 1'b1, RET, 8'h00);
    nchk++; if (pc !== 8'h41 || sp !== 3'd1) begin nerr++; $display("FAIL ret1: got pc=%h sp=%0d want 41 1", pc, sp); end
    drive(1'b1, 1'b1, RET, 8'h00);
    nchk++; if (pc !== 8'h11 || sp !== 3'd0 || empty !== 1'b1) begin nerr++; $display("FAIL ret2: got pc=%h sp=%0d empty=%b want 11 0 1", pc, sp, empty); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nchk++;
      if (o !== e) begin nerr++; $display("FAIL nested_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_overflow();
    drive(1'b0, 1'b0, HOLD, 8'h00);
    for (int i = 1; i <= 4; i++) drive(1'b1, 1'b1, CALL, 8'(i * 16));
    nchk++; if (full !== 1'b1 || sp !== 3'd4) begin nerr++; $display("FAIL ovf_full: got full=%b sp=%0d want 1 4", full, sp); end
    drive(1'b1, 1'b1, CALL, 8'h20);
`ifdef PC_STACK_TRAP_EN
    nchk++; if (pc !== 8'h40 || sp !== 3'd4 || err !== 1'b1) begin nerr++; $display("FAIL ovf_trap: got pc=%h sp=%0d err=%b want 40 4 1", pc, sp, err); end
    drive(1'b1, 1'b1, HOLD, 8'h00);
    nchk++; if (err !== 1'b1) begin nerr++; $display("FAIL ovf_sticky: got err=%b want 1", err); end
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, RET, 8'h00);
    nchk++; if (pc !== 8'h40 || sp !== 3'd4) begin nerr++; $display("FAIL ovf_frozen: got pc=%h sp=%0d want 40 4", pc, sp); end
`else
    nchk++; if (pc !== 8'h20 || sp !== 3'd4 || err !== 1'b1) begin nerr++; $display("FAIL ovf_pulse: got pc=%h sp=%0d err=%b want 20 4 1", pc, sp, err); end
    drive(1'b1, 1'b1, HOLD, 8'h00);
    nchk++; if (err !== 1'b0) begin nerr++; $display("FAIL ovf_clear: got err=%b want 0", err); end
    drive(1'b1, 1'b1, RET, 8'h00);
    nchk++; if (pc !== 8'h31) begin nerr++; $display("FAIL unwind1: got %h want 31", pc); end
    drive(1'b1, 1'b1, RET, 8'h00);
    nchk++; if (pc !== 8'h21) begin nerr++; $display("FAIL unwind2: got %h want 21", pc); end
    drive(1'b1, 1'b1, RET, 8'h00);
    nchk++; if (pc !== 8'h11) begin nerr++; $display("FAIL unwind3: got %h want 11", pc); end
    drive(1'b1, 1'b1, RET, 8'h00);
    nchk++; if (pc !== 8'h01 || empty !== 1'b1) begin nerr++; $display("FAIL unwind4: got pc=%h empty=%b want 01 1", pc, empty); end
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nchk++;
      if (o !== e) begin nerr++; $display("FAIL ovf_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_underflow();
    drive(1'b0, 1'b0, HOLD, 8'h00);
    drive(1'b1, 1'b1, JMP, 8'h05);
    drive(1'b1, 1'b1, RET, 8'h00);
`ifdef PC_STACK_TRAP_EN
    nchk++; if (pc !== 8'h05 || err !== 1'b1) begin nerr++; $display("FAIL udf_trap: got pc=%h err=%b want 05 1", pc, err); end
    drive(1'b1, 1'b1, JMP, 8'h30);
    drive(1'b1, 1'b1, CLR, 8'h00);
    nchk++; if (pc !== 8'h05 || err !== 1'b1) begin nerr++; $display("FAIL udf_ignore: got pc=%h err=%b want 05 1", pc, err); end
`else
    nchk++; if (pc !== 8'h06 || sp !== 3'd0 || err !== 1'b1) begin nerr++; $display("FAIL udf_pulse: got pc=%h sp=%0d err=%b want 06 0 1", pc, sp, err); end
    drive(1'b1, 1'b1, JMP, 8'h30);
    drive(1'b1, 1'b1, CLR, 8'h00);
    nchk++; if (pc !== 8'h30 || err !== 1'b0) begin nerr++; $display("FAIL udf_after: got pc=%h err=%b want 30 0", pc, err); end
`endif
    drive(1'b0, 1'b1, HOLD, 8'h00);
    nchk++; if (pc !== 8'h00 || err !== 1'b0) begin nerr++; $display("FAIL udf_reset: got pc=%h err=%b want 00 0", pc, err); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nchk++;
      if (o !== e) begin nerr++; $display("FAIL udf_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_en_gating();
    drive(1'b0, 1'b0, HOLD, 8'h00);
    drive(1'b1, 1'b1, JMP, 8'h12);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, JMP, 8'h77);
    nchk++; if (pc !== 8'h12) begin nerr++; $display("FAIL en_hold: got %h want 12", pc); end
    drive(1'b1, 1'b1, RET, 8'h00);
    drive(1'b1, 1'b0, INC, 8'h00);
    nchk++; if (err !== 1'b1) begin nerr++; $display("FAIL en_err_hold: got %b want 1", err); end
    drive(1'b0, 1'b1, HOLD, 8'h00);
    drive(1'b1, 1'b1, CALL, 8'h60);
    drive(1'b0, 1'b1, CALL, 8'h90);
    nchk++; if (pc !== 8'h00 || sp !== 3'd0) begin nerr++; $display("FAIL rst_mid_call: got pc=%h sp=%0d want 00 0", pc, sp); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nchk++;
      if (o !== e) begin nerr++; $display("FAIL en_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_clr();
    drive(1'b0, 1'b0, HOLD, 8'h00);
    drive(1'b1, 1'b1, CALL, 8'h10);
    drive(1'b1, 1'b1, CALL, 8'h20);
    drive(1'b1, 1'b1, CALL, 8'h30);
    drive(1'b1, 1'b1, CLR, 8'h00);
    nchk++; if (sp !== 3'd0 || empty !== 1'b1 || pc !== 8'h30) begin nerr++; $display("FAIL clr: got sp=%0d empty=%b pc=%h want 0 1 30", sp, empty, pc); end
    drive(1'b1, 1'b1, RET, 8'h00);
`ifdef PC_STACK_TRAP_EN
    nchk++; if (pc !== 8'h30 || err !== 1'b1) begin nerr++; $display("FAIL clr_ret: got pc=%h err=%b want 30 1", pc, err); end
`else
    nchk++; if (pc !== 8'h31 || err !== 1'b1) begin nerr++; $display("FAIL clr_ret: got pc=%h err=%b want 31 1", pc, err); end
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nchk++;
      if (o !== e) begin nerr++; $display("FAIL clr_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b0, HOLD, 8'h00);
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 99) > 2, $urandom_range(0, 9) > 1, 3'($urandom_range(0, 7)), 8'($urandom));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nchk++;
      if (o !== e) begin nerr++; $display("FAIL b2b_sb: got %h want %h", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_inc_wrap();
    test_nested();
    test_overflow();
    test_underflow();
    test_en_gating();
    test_clr();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
